// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD-line engine: receives 48-bit host commands, tracks card state, sends R1/R2/R3/R6/R7.
// Latency: decode one ex_clk after the end-bit strobe; response start bit NCR+1 strobes after the end bit.
// Flow: paced by sd_bit_en only; cmd_in is ignored while a response is pending or being driven.
//
// Ports: ex_clk/reset_n (async active-low), sd_bit_en bit strobe, cmd_in/cmd_out/cmd_oe CMD pad,
//        cid_data/csd_data/ocr_data/rca_seed register inputs, card_state/rca status outputs,
//        cmd_valid/cmd_index/cmd_arg decoded-command export.
// Option: define SD_CMD_CRC_CHECK_EN to reject received frames with a bad CRC7 (and set COM_CRC_ERROR).
module sd_card_cmd_responder #(
   parameter int BUSY_POLLS = 2,
   parameter int NCR        = 2
) (
   input  logic         ex_clk,
   input  logic         reset_n,
   input  logic         sd_bit_en,
   input  logic         cmd_in,
   output logic         cmd_out,
   output logic         cmd_oe,
   input  logic [127:0] cid_data,
   input  logic [127:0] csd_data,
   input  logic [31:0]  ocr_data,
   input  logic [15:0]  rca_seed,
   output logic [2:0]   card_state,
   output logic [15:0]  rca,
   output logic         cmd_valid,
   output logic [5:0]   cmd_index,
   output logic [31:0]  cmd_arg
);

   typedef enum logic [2:0] {RX_IDLE, RX_SHIFT, DECODE, GAP, TX} fsm_t;
   typedef enum logic [2:0] {K_NONE, K_R1, K_R6, K_R7, K_R2_CID, K_R2_CSD, K_R3} kind_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_READY = 3'd1;
   localparam logic [2:0] ST_IDENT = 3'd2;
   localparam logic [2:0] ST_STBY  = 3'd3;
   localparam logic [2:0] ST_TRAN  = 3'd4;

   localparam logic [3:0] BUSY_MAX = 4'(BUSY_POLLS);
   localparam logic [6:0] NCR_CNT  = 7'(NCR);

   fsm_t         fsm;
   logic [47:0]  rx_sr;
   logic [5:0]   rx_cnt;
   logic [6:0]   gap_cnt;
   logic [135:0] tx_sr;
   logic [7:0]   tx_len;
   logic [7:0]   tx_cnt;
   logic         crc_err;
   logic         ill_cmd;
   logic         app_flag;
   logic [3:0]   acmd41_cnt;

   // CRC7, polynomial x^7 + x^3 + 1, zero seed, MSB first.
   function automatic logic [6:0] crc7_40(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   // Decode of the frame held in rx_sr; only consumed while fsm == DECODE.
   logic [5:0]   f_idx;
   logic [31:0]  f_arg;
   logic         rca_match;
   logic         crc_bad;
   logic         frame_ok;
   kind_t        d_kind;
   logic [2:0]   d_state;
   logic [15:0]  d_rca;
   logic [3:0]   d_cnt;
   logic         d_app;
   logic         d_ill;
   logic         d_busy;
   logic [31:0]  status;
   logic [31:0]  pl48;
   logic [39:0]  body40;
   logic [135:0] rsp_sr;
   logic [7:0]   rsp_len;
   logic         unused_bits;

`ifdef SD_CMD_CRC_CHECK_EN
   assign crc_bad     = (crc7_40(rx_sr[47:8]) != rx_sr[7:1]);
   assign unused_bits = ^{cid_data[0], csd_data[0], ocr_data[31], rx_sr[47]};
`else
   assign crc_bad     = 1'b0;
   assign unused_bits = ^{cid_data[0], csd_data[0], ocr_data[31], rx_sr[47], rx_sr[7:1]};
`endif

   always_comb begin
      f_idx     = rx_sr[45:40];
      f_arg     = rx_sr[39:8];
      rca_match = (f_arg[31:16] == rca);
      frame_ok  = rx_sr[46] & rx_sr[0] & ~crc_bad;
      d_kind    = K_NONE;
      d_state   = card_state;
      d_rca     = rca;
      d_cnt     = acmd41_cnt;
      d_app     = 1'b0;
      d_ill     = 1'b0;
      d_busy    = 1'b0;

      // Only index 41 lives in the ACMD table; any other index after CMD55 decodes as a plain command.
      if (app_flag && f_idx == 6'd41) begin
         if (card_state == ST_IDLE) begin
            d_kind = K_R3;
            // A zero voltage window is an inquiry: report OCR but do not advance initialisation.
            if (f_arg[23:0] != 24'd0) begin
               if (acmd41_cnt < BUSY_MAX)
                  d_cnt = acmd41_cnt + 4'd1;
               d_busy = (d_cnt == BUSY_MAX);
               if (d_busy)
                  d_state = ST_READY;
            end
         end else begin
            d_ill = 1'b1;
         end
      end else begin
         case (f_idx)
            6'd0: begin
               d_state = ST_IDLE;
               d_rca   = 16'd0;
               d_cnt   = 4'd0;
            end
            6'd8: begin
               if (card_state != ST_IDLE)
                  d_ill = 1'b1;
               else if (f_arg[11:8] == 4'b0001)
                  d_kind = K_R7;
            end
            6'd55: begin
               if (card_state == ST_IDLE && rca != 16'd0) begin
                  d_ill = 1'b1;
               end else begin
                  d_kind = K_R1;
                  d_app  = 1'b1;
               end
            end
            6'd2: begin
               if (card_state == ST_READY) begin
                  d_kind  = K_R2_CID;
                  d_state = ST_IDENT;
               end else begin
                  d_ill = 1'b1;
               end
            end
            6'd3: begin
               if (card_state == ST_IDENT || card_state == ST_STBY) begin
                  d_kind  = K_R6;
                  d_rca   = rca_seed;
                  d_state = ST_STBY;
               end else begin
                  d_ill = 1'b1;
               end
            end
            6'd9: begin
               if (card_state == ST_STBY && rca_match)
                  d_kind = K_R2_CSD;
               else
                  d_ill = 1'b1;
            end
            6'd13: begin
               if ((card_state == ST_STBY || card_state == ST_TRAN) && rca_match)
                  d_kind = K_R1;
               else
                  d_ill = 1'b1;
            end
            6'd7: begin
               if (card_state == ST_STBY && rca_match) begin
                  d_kind  = K_R1;
                  d_state = ST_TRAN;
               end else if (card_state == ST_TRAN && !rca_match) begin
                  d_state = ST_STBY;
               end else if (!(card_state == ST_STBY && !rca_match)) begin
                  d_ill = 1'b1;
               end
            end
            default: d_ill = 1'b1;
         endcase
      end

      // Card status reports the state at command receipt and the latches as they stood before it.
      status = {8'd0, crc_err, ill_cmd, 9'd0, 1'b0, card_state, 1'b1, 2'b00, d_app, 5'd0};

      case (d_kind)
         K_R6:    pl48 = {rca_seed, status[23], status[22], status[19], status[12:0]};
         K_R7:    pl48 = {20'd0, f_arg[11:0]};
         default: pl48 = status;
      endcase
      body40 = {2'b00, f_idx, pl48};

      case (d_kind)
         K_R2_CID: begin
            rsp_sr  = {2'b00, 6'h3F, cid_data[127:1], 1'b1};
            rsp_len = 8'd136;
         end
         K_R2_CSD: begin
            rsp_sr  = {2'b00, 6'h3F, csd_data[127:1], 1'b1};
            rsp_len = 8'd136;
         end
         K_R3: begin
            rsp_sr  = {2'b00, 6'h3F, d_busy, ocr_data[30:0], 7'h7F, 1'b1, 88'd0};
            rsp_len = 8'd48;
         end
         default: begin
            rsp_sr  = {body40, crc7_40(body40), 1'b1, 88'd0};
            rsp_len = 8'd48;
         end
      endcase
   end

   always_ff @(posedge ex_clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm        <= RX_IDLE;
         rx_sr      <= '0;
         rx_cnt     <= '0;
         gap_cnt    <= '0;
         tx_sr      <= '0;
         tx_len     <= '0;
         tx_cnt     <= '0;
         crc_err    <= 1'b0;
         ill_cmd    <= 1'b0;
         app_flag   <= 1'b0;
         acmd41_cnt <= '0;
         cmd_out    <= 1'b1;
         cmd_oe     <= 1'b0;
         card_state <= ST_IDLE;
         rca        <= '0;
         cmd_valid  <= 1'b0;
         cmd_index  <= '0;
         cmd_arg    <= '0;
      end else begin
         cmd_valid <= 1'b0;
         case (fsm)
            RX_IDLE: begin
               if (sd_bit_en && !cmd_in) begin
                  rx_sr  <= '0;
                  rx_cnt <= 6'd1;
                  fsm    <= RX_SHIFT;
               end
            end
            RX_SHIFT: begin
               if (sd_bit_en) begin
                  rx_sr <= {rx_sr[46:0], cmd_in};
                  if (rx_cnt == 6'd47)
                     fsm <= DECODE;
                  else
                     rx_cnt <= rx_cnt + 6'd1;
               end
            end
            DECODE: begin
               if (frame_ok) begin
                  cmd_valid  <= 1'b1;
                  cmd_index  <= f_idx;
                  cmd_arg    <= f_arg;
                  card_state <= d_state;
                  rca        <= d_rca;
                  acmd41_cnt <= d_cnt;
                  app_flag   <= d_app;
                  // Latches are only cleared by an R1/R6, which never coincides with an illegal command.
                  if (d_kind == K_R1 || d_kind == K_R6) begin
                     crc_err <= 1'b0;
                     ill_cmd <= 1'b0;
                  end else if (d_ill) begin
                     ill_cmd <= 1'b1;
                  end
                  if (d_kind != K_NONE) begin
                     tx_sr   <= rsp_sr;
                     tx_len  <= rsp_len;
                     gap_cnt <= '0;
                     fsm     <= GAP;
                  end else begin
                     fsm <= RX_IDLE;
                  end
               end else begin
                  if (crc_bad)
                     crc_err <= 1'b1;
                  fsm <= RX_IDLE;
               end
            end
            GAP: begin
               // NCR idle strobes, then the strobe after them drives the start bit.
               if (sd_bit_en) begin
                  if (gap_cnt == NCR_CNT) begin
                     cmd_oe  <= 1'b1;
                     cmd_out <= tx_sr[135];
                     tx_sr   <= {tx_sr[134:0], 1'b1};
                     tx_cnt  <= 8'd1;
                     fsm     <= TX;
                  end else begin
                     gap_cnt <= gap_cnt + 7'd1;
                  end
               end
            end
            TX: begin
               if (sd_bit_en) begin
                  if (tx_cnt == tx_len) begin
                     cmd_oe  <= 1'b0;
                     cmd_out <= 1'b1;
                     fsm     <= RX_IDLE;
                  end else begin
                     cmd_out <= tx_sr[135];
                     tx_sr   <= {tx_sr[134:0], 1'b1};
                     tx_cnt  <= tx_cnt + 8'd1;
                  end
               end
            end
            default: fsm <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
`timescale 1ns/1ps
module tb_sd_card_cmd_responder;
   localparam int NCR        = 2;
   localparam int BUSY_POLLS = 2;
   localparam logic [127:0] CID = 128'h0123456789ABCDEFFEDCBA9876543211;
   localparam logic [127:0] CSD = 128'h400E00325B5900003B377F800A404001;

   logic         ex_clk    = 1'b0;
   logic         reset_n   = 1'b0;
   logic         sd_bit_en = 1'b0;
   logic         cmd_in    = 1'b1;
   logic         cmd_out;
   logic         cmd_oe;
   logic [127:0] cid_data  = CID;
   logic [127:0] csd_data  = CSD;
   logic [31:0]  ocr_data  = 32'h00FF8000;
   logic [15:0]  rca_seed  = 16'h1234;
   logic [2:0]   card_state;
   logic [15:0]  rca;
   logic         cmd_valid;
   logic [5:0]   cmd_index;
   logic [31:0]  cmd_arg;

   sd_card_cmd_responder #(.BUSY_POLLS(BUSY_POLLS), .NCR(NCR)) dut (
      .ex_clk(ex_clk), .reset_n(reset_n), .sd_bit_en(sd_bit_en), .cmd_in(cmd_in),
      .cmd_out(cmd_out), .cmd_oe(cmd_oe), .cid_data(cid_data), .csd_data(csd_data),
      .ocr_data(ocr_data), .rca_seed(rca_seed), .card_state(card_state), .rca(rca),
      .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg)
   );

   always #5 ex_clk = ~ex_clk;

   // One strobe every fourth cycle, changed on the falling edge.
   int ph = 0;
   always @(negedge ex_clk) begin
      ph = (ph + 1) % 4;
      sd_bit_en = (ph == 0);
   end

   int cyc = 0;
   int strobe_n = 0;
   always @(posedge ex_clk) begin
      cyc++;
      if (sd_bit_en) strobe_n++;
   end

   typedef struct { int len; logic [135:0] bits; int start; } rsp_t;
   typedef struct { logic [5:0] idx; logic [31:0] arg; int cyc; } cmd_t;
   rsp_t rsp_q[$];
   cmd_t cmd_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   abort_rsp = 1'b0;
   int   last_k;
   int   last_cyc;

   task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   function automatic logic [47:0] hframe(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] b;
      b = {2'b01, idx, arg};
      return {b, crc7(b), 1'b1};
   endfunction

   function automatic logic [135:0] r48(input logic [5:0] idx, input logic [31:0] pl);
      logic [39:0] b;
      b = {2'b00, idx, pl};
      return {88'd0, b, crc7(b), 1'b1};
   endfunction

   function automatic logic [135:0] r3(input logic [31:0] ocr);
      return {88'd0, 2'b00, 6'h3F, ocr, 7'h7F, 1'b1};
   endfunction

   function automatic logic [135:0] r2(input logic [127:0] rg);
      return {2'b00, 6'h3F, rg[127:1], 1'b1};
   endfunction

   // Response monitor: collects driven bits per strobe and compares against the scoreboard.
   initial begin : tx_mon
      int nb;
      int st;
      logic [135:0] acc;
      rsp_t e;
      nb = 0; st = 0; acc = '0;
      forever begin
         @(posedge ex_clk);
         if (sd_bit_en) begin
            #1;
            if (cmd_oe) begin
               if (nb == 0) st = strobe_n;
               acc = {acc[134:0], cmd_out};
               nb++;
            end else if (nb != 0) begin
               if (abort_rsp) begin
                  abort_rsp = 1'b0;
               end else if (rsp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_rsp: got %0d bits %0h, required none", nb, acc);
               end else begin
                  e = rsp_q.pop_front();
                  chki("rsp_len", nb, e.len);
                  chk("rsp_bits", acc, e.bits);
                  chki("rsp_start_strobe", st, e.start);
               end
               nb = 0; acc = '0;
            end
         end
      end
   end

   // Decoded-command monitor.
   initial begin : cv_mon
      cmd_t e;
      forever begin
         @(negedge ex_clk);
         if (cmd_valid) begin
            if (cmd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_cmd_valid: got index %0d arg %0h, required none", cmd_index, cmd_arg);
            end else begin
               e = cmd_q.pop_front();
               chk("cmd_index", 136'(cmd_index), 136'(e.idx));
               chk("cmd_arg", 136'(cmd_arg), 136'(e.arg));
               chki("cmd_valid_cycle", cyc, e.cyc + 1);
            end
         end
      end
   end

   task automatic wait_strobes(input int n);
      repeat (n) begin
         do @(posedge ex_clk); while (!sd_bit_en);
         #1;
      end
   endtask

   task automatic send_frame(input logic [47:0] f);
      for (int i = 47; i >= 0; i--) begin
         cmd_in = f[i];
         do @(posedge ex_clk); while (!sd_bit_en);
         #1;
      end
      cmd_in   = 1'b1;
      last_k   = strobe_n;
      last_cyc = cyc;
   endtask

   task automatic expect_cmd(input logic [47:0] f);
      cmd_t c;
      c.idx = f[45:40]; c.arg = f[39:8]; c.cyc = last_cyc;
      cmd_q.push_back(c);
   endtask

   task automatic run(input string name, input logic [47:0] f, input bit exp_valid,
                      input int len, input logic [135:0] bits);
      rsp_t r;
      int   t;
      send_frame(f);
      if (exp_valid) expect_cmd(f);
      if (len != 0) begin
         r.len = len; r.bits = bits; r.start = last_k + NCR + 1;
         rsp_q.push_back(r);
      end
      t = 0;
      while (rsp_q.size() != 0 && t < 2000) begin
         @(posedge ex_clk);
         t++;
      end
      wait_strobes(3);
      checks++;
      if (rsp_q.size() != 0 || cmd_q.size() != 0) begin
         errors++;
         $display("FAIL %s: pending rsp/cmd %0d/%0d, required 0/0", name, rsp_q.size(), cmd_q.size());
         rsp_q.delete();
         cmd_q.delete();
      end
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin : stim
      int t;
      logic [47:0] f;
      repeat (3) @(negedge ex_clk);
      chk("rst_cmd_oe", 136'(cmd_oe), 136'(0));
      chk("rst_cmd_out", 136'(cmd_out), 136'(1));
      chk("rst_card_state", 136'(card_state), 136'(0));
      chk("rst_rca", 136'(rca), 136'(0));
      chk("rst_cmd_valid", 136'(cmd_valid), 136'(0));
      chk("rst_cmd_index", 136'(cmd_index), 136'(0));
      chk("rst_cmd_arg", 136'(cmd_arg), 136'(0));
      reset_n = 1'b1;
      wait_strobes(4);

      run("cmd0", 48'h400000000095, 1'b1, 0, '0);
      run("cmd8", 48'h48000001AA87, 1'b1, 48, {88'd0, 48'h08000001AA13});
      chk("state_after_cmd8", 136'(card_state), 136'(0));

      run("cmd55_a", hframe(6'd55, 32'h0), 1'b1, 48, r48(6'd55, 32'h00000120));
      run("acmd41_a", hframe(6'd41, 32'h40FF8000), 1'b1, 48, r3(32'h00FF8000));
      chk("state_after_acmd41_a", 136'(card_state), 136'(0));
      run("cmd55_b", hframe(6'd55, 32'h0), 1'b1, 48, r48(6'd55, 32'h00000120));
      run("acmd41_b", hframe(6'd41, 32'h40FF8000), 1'b1, 48, r3(32'h80FF8000));
      chk("state_after_acmd41_b", 136'(card_state), 136'(1));

      run("cmd2", hframe(6'd2, 32'h0), 1'b1, 136, r2(CID));
      chk("state_after_cmd2", 136'(card_state), 136'(2));
      run("cmd3", hframe(6'd3, 32'h0), 1'b1, 48, r48(6'd3, 32'h12340500));
      chk("state_after_cmd3", 136'(card_state), 136'(3));
      chk("rca_after_cmd3", 136'(rca), 136'(16'h1234));

      f = hframe(6'd13, 32'h12340000) ^ 48'h2;
`ifdef SD_CMD_CRC_CHECK_EN
      run("cmd13_badcrc", f, 1'b0, 0, '0);
      run("cmd13_crcflag", hframe(6'd13, 32'h12340000), 1'b1, 48, r48(6'd13, 32'h00800700));
`else
      run("cmd13_badcrc", f, 1'b1, 48, r48(6'd13, 32'h00000700));
      run("cmd13_crcflag", hframe(6'd13, 32'h12340000), 1'b1, 48, r48(6'd13, 32'h00000700));
`endif
      run("cmd13_badend", hframe(6'd13, 32'h12340000) ^ 48'h1, 1'b0, 0, '0);
      run("cmd13_clear", hframe(6'd13, 32'h12340000), 1'b1, 48, r48(6'd13, 32'h00000700));

      run("cmd7_other", hframe(6'd7, 32'h56780000), 1'b1, 0, '0);
      chk("state_after_cmd7_other", 136'(card_state), 136'(3));
      run("cmd7_sel", hframe(6'd7, 32'h12340000), 1'b1, 48, r48(6'd7, 32'h00000700));
      chk("state_after_cmd7_sel", 136'(card_state), 136'(4));

      run("cmd2_illegal", hframe(6'd2, 32'h0), 1'b1, 0, '0);
      run("cmd13_tran", hframe(6'd13, 32'h12340000), 1'b1, 48, r48(6'd13, 32'h00400900));
      run("cmd7_desel", hframe(6'd7, 32'h56780000), 1'b1, 0, '0);
      chk("state_after_cmd7_desel", 136'(card_state), 136'(3));
      run("cmd9", hframe(6'd9, 32'h12340000), 1'b1, 136, r2(CSD));

      // Reset in the middle of the 60th bit of an R2.
      abort_rsp = 1'b1;
      f = hframe(6'd9, 32'h12340000);
      send_frame(f);
      expect_cmd(f);
      t = 0;
      while (strobe_n < last_k + NCR + 60 && t < 4000) begin
         @(posedge ex_clk);
         #1;
         t++;
      end
      chk("oe_before_reset", 136'(cmd_oe), 136'(1));
      #2;
      reset_n = 1'b0;
      #1;
      chk("oe_async_reset", 136'(cmd_oe), 136'(0));
      repeat (3) @(negedge ex_clk);
      chk("reset_cmd_out", 136'(cmd_out), 136'(1));
      chk("reset_card_state", 136'(card_state), 136'(0));
      chk("reset_rca", 136'(rca), 136'(0));
      chk("reset_cmd_index", 136'(cmd_index), 136'(0));
      reset_n = 1'b1;
      wait_strobes(3);
      chk("aborted_rsp_seen", 136'(abort_rsp), 136'(0));

      run("cmd8_after_reset", 48'h48000001AA87, 1'b1, 48, {88'd0, 48'h08000001AA13});
      chk("state_after_reset_cmd8", 136'(card_state), 136'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sd_card_cmd_responder.md
# sd_card_cmd_responder

- Card-side CMD-line engine: the responding end of the SD command protocol that the host FSM initiates.
- Deserializes 48-bit host command frames and checks CRC7.
- Tracks the card identification/transfer state and serializes R1/R2/R3/R6/R7 responses.
- Sits in the card model/emulator path, driven by a bit strobe derived from `ex_clk`.
- Exports decoded commands to downstream data-path blocks.

## Interface
- `BUSY_POLLS`, default 2: ACMD41 count (1..15) before OCR busy bit [31] reads 1.
- `NCR`, default 2: idle bit times between command end bit and response start bit (2..64).
- `ex_clk` in 1: system clock; every flop is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sd_bit_en` in 1: one-cycle SD bit strobe; never asserted on two consecutive cycles.
- `cmd_in` in 1: CMD line as sampled from the pad.
- `cmd_out` out 1: driven CMD bit.
- `cmd_oe` out 1: CMD output enable.
- `cid_data` in 128: CID register; bit 0 ignored.
- `csd_data` in 128: CSD register; bit 0 ignored.
- `ocr_data` in 32: OCR; bit 31 replaced by the busy logic.
- `rca_seed` in 16: RCA published by CMD3.
- `card_state` out 3: 0 IDLE, 1 READY, 2 IDENT, 3 STBY, 4 TRAN.
- `rca` out 16: current RCA.
- `cmd_valid` out 1: one-cycle pulse per accepted frame.
- `cmd_index` out 6 and `cmd_arg` out 32: last accepted frame; held until the next one.

## Operation
- Receiver FSM: RX_IDLE, RX_SHIFT, DECODE, GAP, TX, then back to RX_IDLE.
- RX_IDLE → RX_SHIFT: a strobe samples `cmd_in`=0.
- RX_SHIFT shifts 47 more bits MSB first.
- Frame layout: start 0, transmission bit 1, index[5:0], arg[31:0], CRC7 (x^7+x^3+1 over the first 40 bits), end 1.
- Frame rejected when any of these holds: transmission bit 0, end bit 0, or CRC mismatch.
- On a rejected frame:
  - CRC mismatch sets the COM_CRC_ERROR latch; other rejections set no latch.
  - No response; return to RX_IDLE.
- Accepted frame: `cmd_valid` pulses. Decode against `card_state`; the app flag selects the ACMD table.
- CMD0, any state: IDLE, RCA=0, ACMD41 counter=0, app flag cleared. No response.
- CMD8, IDLE:
  - arg[11:8]==4'b0001: R7 echoing arg[11:0].
  - Otherwise: no response.
- CMD55, any state except IDLE-with-nonzero-RCA: R1 with APP_CMD bit 5 set; app flag set.
- The app flag clears on the next accepted frame.
- ACMD41, IDLE, arg[23:0]≠0:
  - Increment the counter, saturating at BUSY_POLLS.
  - R3 = `ocr_data` with bit 31 = (counter==BUSY_POLLS).
  - Busy bit 1 → READY.
- ACMD41 with arg[23:0]=0: R3, busy 0, counter unchanged, state unchanged.
- CMD2, READY: R2 carrying CID, then IDENT.
- CMD3, IDENT or STBY: R6 = {rca_seed, status[23,22,19,12:0]}; RCA←rca_seed; then STBY.
- CMD9, STBY, arg[31:16]==RCA: R2 carrying CSD.
- CMD13, STBY/TRAN, RCA match: R1.
- CMD7:
  - STBY with RCA match: R1, then TRAN.
  - TRAN with mismatch: STBY, no response.
  - STBY with mismatch: ignored, no response.
- Any other index/state combination, or an RCA mismatch on CMD9/CMD13: ILLEGAL_COMMAND latch set, no response.
- R1 card status bits:
  - 23 COM_CRC_ERROR, 22 ILLEGAL_COMMAND.
  - 12:9 state at command receipt.
  - 8 READY_FOR_DATA=1, 5 APP_CMD.
  - All other bits 0.
  - Both latches clear once reported in an R1 or R6.
- Response formats, each followed by end bit 1:
  - R1/R6/R7: 0, 0, index, 32-bit payload, CRC7.
  - R2: 0, 0, 111111, reg[127:1].
  - R3: 0, 0, 111111, OCR, 1111111.

## Timing
- Reset values:
  - `cmd_oe`=0, `cmd_out`=1, `card_state`=0, `rca`=0.
  - `cmd_valid`=0, `cmd_index`=0, `cmd_arg`=0.
  - Latches, app flag and counter all 0.
- Reset is effective immediately, including mid-frame and mid-response; `cmd_oe` falls asynchronously.
- `cmd_in` is sampled only on `sd_bit_en` cycles.
- `cmd_valid`, decode, state update and latch update all occur one `ex_clk` after the end-bit strobe k.
- No-response frames return to RX_IDLE right after decode.
- Strobes k+1..k+NCR: `cmd_oe`=0.
- Strobe k+NCR+1: `cmd_oe`=1 and the start bit is driven; `cmd_out` advances one bit per strobe.
- `cmd_oe` drops on the strobe after the end bit: 48 strobes of drive for R1/R3/R6/R7, 136 for R2.
- `cmd_in` is ignored while in GAP and TX.

## Configuration
- `SD_CMD_CRC_CHECK_EN` defined: CRC7 of received frames is verified as described above.
- Undefined:
  - The CRC field is shifted but ignored.
  - COM_CRC_ERROR is never set.
  - Response CRC7 generation is unaffected.

## Test plan
- CMD0 frame 0x400000000095, then CMD8 frame 0x48000001AA87 → R7, index 8, payload 0x000001AA, start bit at strobe k+3, `card_state`=0.
- CMD55, ACMD41 arg 0x40FF8000 twice (BUSY_POLLS=2):
  - First R3: OCR[31]=0, state stays IDLE.
  - Second R3: OCR[31]=1, `card_state`=1.
- CMD2 → 136-bit R2 equal to `cid_data`[127:1], `card_state`=2; CMD3 with `rca_seed`=0x1234 → R6 payload[31:16]=0x1234, `card_state`=3.
- CMD13 (arg 0x12340000) with a flipped CRC bit → no `cmd_valid`, no drive. The next CMD13 R1 has bit 23=1 and [12:9]=3; the following CMD13 has bit 23=0.
- CMD7 arg 0x56780000 in STBY → no response, state stays 3. CMD7 arg 0x12340000 → R1 [12:9]=3, `card_state`=4.
- `reset_n` low during the 60th bit of an R2 → `cmd_oe`=0 with no clock edge. After release: `card_state`=0, `rca`=0, and CMD8 is answered normally.
